// File: rtl/game_controller.sv
// game_controller -- sequencing FSM for a note-following rhythm game.
//
// Walks through IDLE -> COUNTDOWN -> PLAY -> DONE/FAIL, with PAUSE reachable
// from PLAY. It also tracks consecutive missed notes.
//
// Parameters
//   COUNTDOWN_TICKS  tick pulses spent in COUNTDOWN before play starts
//   MAX_MISS         consecutive misses that end the game in FAIL (1..15)
//
// Optional feature macro: GAME_CONTROLLER_FAIL_EN
//   defined   -> reaching MAX_MISS consecutive misses enters FAIL
//   undefined -> FAIL is unreachable; miss_cnt saturates at 15 and play
//                continues until the song ends
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start_btn     debounced start button (level)
//   pause_btn     debounced pause button (level)
//   tick          one-cycle note-rate pulse
//   note_present  current song step has a non-zero LED pattern
//   hit           player buttons match the current LED pattern
//   song_last     note counter sits on the final song step
//   step_adv      one-cycle pulse advancing the note counter
//   step_clr      one-cycle pulse clearing note counter and score
//   score_en      point keeper accumulation enable
//   sound_en      sound system enable
//   state         current state code
//   miss_cnt      current consecutive-miss count
module game_controller #(
  parameter int COUNTDOWN_TICKS = 3,
  parameter int MAX_MISS        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       tick,
  input  logic       note_present,
  input  logic       hit,
  input  logic       song_last,
  output logic       step_adv,
  output logic       step_clr,
  output logic       score_en,
  output logic       sound_en,
  output logic [2:0] state,
  output logic [3:0] miss_cnt
);

`ifdef GAME_CONTROLLER_FAIL_EN
  localparam bit FAIL_ENABLED = 1'b1;
`else
  localparam bit FAIL_ENABLED = 1'b0;
`endif

  localparam int TW = (COUNTDOWN_TICKS > 1) ? $clog2(COUNTDOWN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(COUNTDOWN_TICKS - 1);
  localparam logic [3:0]    MISS_LIMIT = 4'(MAX_MISS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    DONE      = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t          state_reg;
  logic            start_prev_reg;
  logic            pause_prev_reg;
  logic            hit_seen_reg;
  logic [3:0]      miss_cnt_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic            step_clr_reg;
  logic            play_en_reg;

  logic start_edge;
  logic pause_edge;
  logic note_miss;
  logic fail_now;

  assign start_edge = start_btn & ~start_prev_reg;
  assign pause_edge = pause_btn & ~pause_prev_reg;

  // A note counts as missed only if no hit was seen during the step,
  // including on the tick cycle itself.
  assign note_miss = note_present & ~hit_seen_reg & ~hit;
  assign fail_now  = FAIL_ENABLED && note_miss && ((miss_cnt_reg + 4'd1) == MISS_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      start_prev_reg <= 1'b0;
      pause_prev_reg <= 1'b0;
      hit_seen_reg   <= 1'b0;
      miss_cnt_reg   <= 4'd0;
      tick_cnt_reg   <= '0;
      step_clr_reg   <= 1'b0;
      play_en_reg    <= 1'b0;
    end else begin
      start_prev_reg <= start_btn;
      pause_prev_reg <= pause_btn;
      step_clr_reg   <= 1'b0;
      // play_en_reg tracks "next state is PLAY"; each path into or
      // staying in PLAY sets it explicitly.
      play_en_reg    <= 1'b0;

      case (state_reg)
        IDLE, DONE, FAIL: begin
          if (start_edge) begin
            state_reg    <= COUNTDOWN;
            step_clr_reg <= 1'b1;
            tick_cnt_reg <= '0;
            miss_cnt_reg <= 4'd0;
            hit_seen_reg <= 1'b0;
          end
        end

        COUNTDOWN: begin
          if (tick) begin
            if (tick_cnt_reg == TICK_LAST) begin
              state_reg    <= PLAY;
              play_en_reg  <= 1'b1;
              tick_cnt_reg <= '0;
              hit_seen_reg <= 1'b0;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        PLAY: begin
          play_en_reg <= 1'b1;
          if (tick) begin
            hit_seen_reg <= 1'b0;
            if (fail_now) begin
              state_reg    <= FAIL;
              miss_cnt_reg <= MISS_LIMIT;
              play_en_reg  <= 1'b0;
            end else if (song_last) begin
              state_reg   <= DONE;
              play_en_reg <= 1'b0;
            end else begin
              if (note_miss) begin
                miss_cnt_reg <= (miss_cnt_reg == 4'd15) ? 4'd15 : miss_cnt_reg + 4'd1;
              end else if (note_present) begin
                miss_cnt_reg <= 4'd0;
              end
              // Tick is handled first; a simultaneous pause still pauses.
              if (pause_edge) begin
                state_reg   <= PAUSE;
                play_en_reg <= 1'b0;
              end
            end
          end else begin
            if (hit) begin
              hit_seen_reg <= 1'b1;
            end
            if (pause_edge) begin
              state_reg   <= PAUSE;
              play_en_reg <= 1'b0;
            end
          end
        end

        PAUSE: begin
          if (start_edge) begin
            state_reg <= IDLE;
          end else if (pause_edge) begin
            state_reg   <= PLAY;
            play_en_reg <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign step_adv = (state_reg == PLAY) && tick;
  assign step_clr = step_clr_reg;
  assign score_en = play_en_reg;
  assign sound_en = play_en_reg;
  assign state    = state_reg;
  assign miss_cnt = miss_cnt_reg;

endmodule
